aibcr3_red_shift_seq: RTL and testbench
=======================================

// Module: aibcr3_red_shift_seq
// PURPOSE
//  Redundancy-repair sequencer upstream of the aibcr3_buffx1_top column.
//  - Converts a failing-IO index into the per-IO thermometer shift_en vector.
//  - Sequences the column resets around each repair so that the redundancy muxes never switch while an IO is live:
//    assert resets -> apply shift -> settle -> release analog reset -> release digital reset.
//  - prev_io_shift_en of IO i is wired from shift_en[i-1].
// PARAMETERS
//  NUM_IO      24  IOs in column (incl. spare at top); 2..32
//  IDX_W        5  width of failing-IO index; 2**IDX_W >= NUM_IO
//  SETTLE_CYC  16  clk cycles waited after each shift/reset step; >=1
//  CNT_W        8  settle counter width; 2**CNT_W > SETTLE_CYC
// PORTS
//  clk            in   1       sequencer clock
//  rst            in   1       async active-high reset
//  cfg_req        in   1       1-cycle pulse: start a repair/unrepair
//  cfg_red_en     in   1       1=repair at cfg_fail_idx, 0=clear all shifts
//  cfg_fail_idx   in   IDX_W   failing IO index, sampled with cfg_req
//  dig_rstb_in    in   1       adapter digital reset request (active-low)
//  anlg_rstb_in   in   1       adapter analog reset request (active-low)
//  cfg_busy       out  1       sequence in progress
//  cfg_ack        out  1       1-cycle pulse at sequence completion
//  cfg_err        out  1       sticky: last request had idx >= NUM_IO
//  shift_en       out  NUM_IO  per-IO shift enable to buffx1_top columns
//  dig_rstb_out   out  1       to buffx1_top dig_rstb
//  anlg_rstb_out  out  1       to buffx1_top anlg_rstb
// BEHAVIOUR
//  Reset values
//   - All outputs are 0: shift_en=0, both rstb outs low, busy/ack/err=0.
//   - FSM state is IDLE.
//  Output logic
//   - All outputs are registered.
//   - dig_rstb_out = dig_rstb_in & dig_gate; anlg_rstb_out = anlg_rstb_in & anlg_gate.
//   - dig_gate and anlg_gate are internal FSM regs. After reset, the FSM sets both gates to 1 in IDLE.
//  FSM states: IDLE, HOLD, SHIFT, SETTLE, REL_A, REL_D, DONE.
//   - IDLE: on cfg_req, latch cfg_red_en/cfg_fail_idx.
//     - If red_en and idx >= NUM_IO: set cfg_err=1, go to DONE; shift_en and resets are unchanged.
//     - Otherwise: clear cfg_err, drop both gates, busy=1, go to HOLD.
//   - HOLD: wait SETTLE_CYC cycles, then go to SHIFT.
//   - SHIFT: one cycle, go to SETTLE.
//     - If red_en: shift_en[i] = (i >= idx).
//     - Else: shift_en = 0.
//   - SETTLE: wait SETTLE_CYC cycles, then go to REL_A.
//   - REL_A: anlg_gate=1; wait SETTLE_CYC cycles, then go to REL_D.
//   - REL_D: dig_gate=1; go to DONE.
//   - DONE: cfg_ack=1 for one cycle, busy=0, go to IDLE.
//  Latency
//   - cfg_req to cfg_ack = 3*SETTLE_CYC + 4 cycles (valid request).
//   - Error case: 2 cycles.
//  Counter behaviour
//   - The counter loads 0 on each state entry.
//   - The exit condition is cnt == SETTLE_CYC-1.
//  Boundaries
//   - cfg_req while busy or in DONE is ignored: no queue, no error.
//   - idx = NUM_IO-1 shifts only the spare. idx = 0 shifts all IOs.
//   - Repeating the same repair re-runs the full sequence (resets still pulse).
//   - Adapter rstb_in low has priority: the output stays low regardless of gate.
//   - rst asserted mid-sequence: immediate return to reset values. The column is left unrepaired and held in reset.
// STRUCTURE
//  - Shared package aibcr3_red_pkg: FSM state enum red_seq_state_t, constant RED_STATE_W.
//  - One sub-module, aibcr3_red_therm: combinational idx -> NUM_IO thermometer with an out-of-range flag. Reused by the unit test.
// TESTING
//  1. Reset: rst=1 mid-SETTLE -> shift_en=0, rstb outs=0, busy=0 next edge; after release, rstb outs follow inputs.
//  2. Repair: NUM_IO=24, SETTLE_CYC=16, cfg_req idx=5 red_en=1.
//     -> shift_en=24'hFFFFE0; ack 52 cycles after req.
//     -> anlg_rstb_out rises 16 cycles before dig_rstb_out.
//  3. Unrepair: after repair idx=5, cfg_req red_en=0 -> shift_en=0 with both resets low throughout the change.
//  4. Range: idx=24 red_en=1 -> cfg_err=1, ack 2 cycles later, shift_en and rstb unchanged.
//     A following valid request clears cfg_err.
//  5. Busy ignore: second cfg_req idx=9 during SETTLE -> no effect; final shift_en reflects the first idx only.
//  6. Priority: dig_rstb_in=0 while IDLE with gates=1 -> dig_rstb_out=0 one cycle later.

Source files
------------

// File: rtl/aibcr3_red_pkg.sv
// ============================================================================
// Module      : aibcr3_red_pkg
// Description : Shared types for the redundancy-repair shift sequencer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package aibcr3_red_pkg;

    localparam int RED_STATE_W = 3;

    typedef enum logic [RED_STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_HOLD   = 3'd1,
        ST_SHIFT  = 3'd2,
        ST_SETTLE = 3'd3,
        ST_REL_A  = 3'd4,
        ST_REL_D  = 3'd5,
        ST_DONE   = 3'd6
    } red_seq_state_t;

endpackage

`default_nettype wire

// File: rtl/aibcr3_red_therm.sv
// ============================================================================
// Module      : aibcr3_red_therm
// Description : Failing-IO index to per-IO thermometer (bit i set for i >= idx)
//               plus an out-of-range flag for idx >= NUM_IO.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aibcr3_red_therm #(
    parameter int NUM_IO = 24,
    parameter int IDX_W  = 5
) (
    input  logic [IDX_W-1:0]  i_idx,
    output logic [NUM_IO-1:0] o_therm,
    output logic              o_oor
);

    logic [31:0] w_idx_ext;

    assign w_idx_ext = 32'(i_idx);
    assign o_oor     = (w_idx_ext >= 32'(NUM_IO));

    genvar i;
    generate
        for (i = 0; i < NUM_IO; i++) begin : g_therm
            assign o_therm[i] = (w_idx_ext <= 32'(i));
        end
    endgenerate

endmodule

`default_nettype wire

// File: rtl/aibcr3_red_shift_seq.sv
// ============================================================================
// Module      : aibcr3_red_shift_seq
// Description : Redundancy-repair sequencer: holds the column in reset, moves
//               the shift_en thermometer, then releases analog and digital
//               resets in order after fixed settle windows.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module aibcr3_red_shift_seq
    import aibcr3_red_pkg::*;
#(
    parameter int NUM_IO     = 24,
    parameter int IDX_W      = 5,
    parameter int SETTLE_CYC = 16,
    parameter int CNT_W      = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_req,
    input  logic              cfg_red_en,
    input  logic [IDX_W-1:0]  cfg_fail_idx,
    input  logic              dig_rstb_in,
    input  logic              anlg_rstb_in,
    output logic              cfg_busy,
    output logic              cfg_ack,
    output logic              cfg_err,
    output logic [NUM_IO-1:0] shift_en,
    output logic              dig_rstb_out,
    output logic              anlg_rstb_out
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(SETTLE_CYC - 1);

    red_seq_state_t    r_state, w_state_nxt;
    logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
    logic              r_dig_gate, w_dig_gate_nxt;
    logic              r_anlg_gate, w_anlg_gate_nxt;
    logic              r_red_en, w_red_en_nxt;
    logic [NUM_IO-1:0] r_therm, w_therm_nxt;
    logic              r_busy, w_busy_nxt;
    logic              r_ack, w_ack_nxt;
    logic              r_err, w_err_nxt;
    logic [NUM_IO-1:0] r_shift_en, w_shift_en_nxt;
    logic              r_dig_rstb, w_dig_rstb_nxt;
    logic              r_anlg_rstb, w_anlg_rstb_nxt;

    logic [NUM_IO-1:0] w_therm;
    logic              w_idx_oor;
    logic              w_cnt_done;

    // Decode the incoming index; the vector is latched so it is stable at SHIFT
    aibcr3_red_therm #(
        .NUM_IO (NUM_IO),
        .IDX_W  (IDX_W)
    ) u_therm (
        .i_idx   (cfg_fail_idx),
        .o_therm (w_therm),
        .o_oor   (w_idx_oor)
    );

    assign w_cnt_done = (r_cnt == c_cnt_last);

    always_comb begin
        w_state_nxt     = r_state;
        w_cnt_nxt       = '0;
        w_dig_gate_nxt  = r_dig_gate;
        w_anlg_gate_nxt = r_anlg_gate;
        w_red_en_nxt    = r_red_en;
        w_therm_nxt     = r_therm;
        w_busy_nxt      = r_busy;
        w_ack_nxt       = 1'b0;
        w_err_nxt       = r_err;
        w_shift_en_nxt  = r_shift_en;

        case (r_state)
            ST_IDLE: begin
                w_dig_gate_nxt  = 1'b1;
                w_anlg_gate_nxt = 1'b1;
                w_busy_nxt      = 1'b0;
                if (cfg_req) begin
                    w_red_en_nxt = cfg_red_en;
                    w_therm_nxt  = w_therm;
                    if (cfg_red_en && w_idx_oor) begin
                        w_err_nxt   = 1'b1;
                        w_state_nxt = ST_DONE;
                    end else begin
                        w_err_nxt       = 1'b0;
                        w_dig_gate_nxt  = 1'b0;
                        w_anlg_gate_nxt = 1'b0;
                        w_busy_nxt      = 1'b1;
                        w_state_nxt     = ST_HOLD;
                    end
                end
            end
            ST_HOLD: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_cnt_done) w_state_nxt = ST_SHIFT;
            end
            ST_SHIFT: begin
                w_shift_en_nxt = r_red_en ? r_therm : '0;
                w_state_nxt    = ST_SETTLE;
            end
            ST_SETTLE: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_cnt_done) begin
                    w_anlg_gate_nxt = 1'b1;
                    w_state_nxt     = ST_REL_A;
                end
            end
            ST_REL_A: begin
                w_cnt_nxt = r_cnt + 1'b1;
                if (w_cnt_done) begin
                    w_dig_gate_nxt = 1'b1;
                    w_state_nxt    = ST_REL_D;
                end
            end
            ST_REL_D: begin
                w_state_nxt = ST_DONE;
            end
            ST_DONE: begin
                w_ack_nxt   = 1'b1;
                w_busy_nxt  = 1'b0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase

        // Every wait window restarts from zero on state entry
        if (w_state_nxt != r_state) w_cnt_nxt = '0;
    end

    // Adapter request low always wins over the sequencer gate
    assign w_dig_rstb_nxt  = dig_rstb_in  & w_dig_gate_nxt;
    assign w_anlg_rstb_nxt = anlg_rstb_in & w_anlg_gate_nxt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_dig_gate  <= 1'b0;
            r_anlg_gate <= 1'b0;
            r_red_en    <= 1'b0;
            r_therm     <= '0;
            r_busy      <= 1'b0;
            r_ack       <= 1'b0;
            r_err       <= 1'b0;
            r_shift_en  <= '0;
            r_dig_rstb  <= 1'b0;
            r_anlg_rstb <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_dig_gate  <= w_dig_gate_nxt;
            r_anlg_gate <= w_anlg_gate_nxt;
            r_red_en    <= w_red_en_nxt;
            r_therm     <= w_therm_nxt;
            r_busy      <= w_busy_nxt;
            r_ack       <= w_ack_nxt;
            r_err       <= w_err_nxt;
            r_shift_en  <= w_shift_en_nxt;
            r_dig_rstb  <= w_dig_rstb_nxt;
            r_anlg_rstb <= w_anlg_rstb_nxt;
        end
    end

    assign cfg_busy      = r_busy;
    assign cfg_ack       = r_ack;
    assign cfg_err       = r_err;
    assign shift_en      = r_shift_en;
    assign dig_rstb_out  = r_dig_rstb;
    assign anlg_rstb_out = r_anlg_rstb;

endmodule

`default_nettype wire

// File: tb/tb_aibcr3_red_shift_seq.sv
// ============================================================================
// Module      : tb_aibcr3_red_shift_seq
// Description : Self-checking bench for aibcr3_red_shift_seq with a
//               behavioural model of the repair sequence.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_aibcr3_red_shift_seq;

    localparam int NUM_IO     = 24;
    localparam int IDX_W      = 5;
    localparam int SETTLE_CYC = 16;
    localparam int CNT_W      = 8;
    localparam int LAT_OK     = 3 * SETTLE_CYC + 4;
    localparam int LAT_ERR    = 2;

    logic              clk;
    logic              rst;
    logic              cfg_req;
    logic              cfg_red_en;
    logic [IDX_W-1:0]  cfg_fail_idx;
    logic              dig_rstb_in;
    logic              anlg_rstb_in;
    logic              cfg_busy;
    logic              cfg_ack;
    logic              cfg_err;
    logic [NUM_IO-1:0] shift_en;
    logic              dig_rstb_out;
    logic              anlg_rstb_out;

    int tests_run;
    int tests_failed;

    // Model state: what the column should look like after the last request
    logic [NUM_IO-1:0] m_shift;
    logic              m_err;

    aibcr3_red_shift_seq #(
        .NUM_IO     (NUM_IO),
        .IDX_W      (IDX_W),
        .SETTLE_CYC (SETTLE_CYC),
        .CNT_W      (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .cfg_req       (cfg_req),
        .cfg_red_en    (cfg_red_en),
        .cfg_fail_idx  (cfg_fail_idx),
        .dig_rstb_in   (dig_rstb_in),
        .anlg_rstb_in  (anlg_rstb_in),
        .cfg_busy      (cfg_busy),
        .cfg_ack       (cfg_ack),
        .cfg_err       (cfg_err),
        .shift_en      (shift_en),
        .dig_rstb_out  (dig_rstb_out),
        .anlg_rstb_out (anlg_rstb_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [NUM_IO-1:0] exp_therm(input int idx);
        logic [31:0] ones;
        ones = 32'hFFFF_FFFF << idx;
        return ones[NUM_IO-1:0];
    endfunction

    // Issues one request and observes the sequence until ack (bounded).
    // k counts posedges after the request is driven.
    task automatic do_req(input logic red_en, input int idx, input int inj_k,
                          input int inj_idx, output int lat, output int a_rise,
                          output int d_rise, output int viol, output int drops);
        logic [NUM_IO-1:0] prev_sh;
        logic              prev_a;
        logic              prev_d;
        @(posedge clk); #1;
        cfg_req      = 1'b1;
        cfg_red_en   = red_en;
        cfg_fail_idx = IDX_W'(idx);
        lat = -1; a_rise = -1; d_rise = -1; viol = 0; drops = 0;
        prev_sh = shift_en; prev_a = anlg_rstb_out; prev_d = dig_rstb_out;
        for (int k = 1; k <= 200; k++) begin
            @(posedge clk); #1;
            if (k == 1) cfg_req = 1'b0;
            if (k == inj_k) begin
                cfg_req      = 1'b1;
                cfg_red_en   = 1'b1;
                cfg_fail_idx = IDX_W'(inj_idx);
            end else if (k == inj_k + 1) begin
                cfg_req = 1'b0;
            end
            if (shift_en !== prev_sh && (dig_rstb_out !== 1'b0 || anlg_rstb_out !== 1'b0))
                viol++;
            if (dig_rstb_out !== 1'b1 || anlg_rstb_out !== 1'b1) drops++;
            if (anlg_rstb_out === 1'b1 && prev_a !== 1'b1 && a_rise < 0) a_rise = k;
            if (dig_rstb_out === 1'b1 && prev_d !== 1'b1 && d_rise < 0) d_rise = k;
            prev_sh = shift_en; prev_a = anlg_rstb_out; prev_d = dig_rstb_out;
            if (cfg_ack === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        tests_run++;
        if ({shift_en, dig_rstb_out, anlg_rstb_out, cfg_busy, cfg_ack, cfg_err} !== '0) begin
            tests_failed++;
            $display("FAIL reset_vals: got shift=%h d=%b a=%b busy=%b ack=%b err=%b expected all 0",
                     shift_en, dig_rstb_out, anlg_rstb_out, cfg_busy, cfg_ack, cfg_err);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (dig_rstb_out !== 1'b1 || anlg_rstb_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL reset_release: got d=%b a=%b expected 1 1", dig_rstb_out, anlg_rstb_out);
        end
        // Reset in the middle of SETTLE after the shift has been applied
        cfg_req = 1'b1; cfg_red_en = 1'b1; cfg_fail_idx = 5'd3;
        for (int k = 1; k <= 20; k++) begin
            @(posedge clk); #1;
            if (k == 1) cfg_req = 1'b0;
        end
        tests_run++;
        if (shift_en !== exp_therm(3) || cfg_busy !== 1'b1) begin
            tests_failed++;
            $display("FAIL mid_settle_shift: got shift=%h busy=%b expected %h 1",
                     shift_en, cfg_busy, exp_therm(3));
        end
        rst = 1'b1;
        @(posedge clk); #1;
        tests_run++;
        if (shift_en !== '0 || dig_rstb_out !== 1'b0 || anlg_rstb_out !== 1'b0 || cfg_busy !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset: got shift=%h d=%b a=%b busy=%b expected 0 0 0 0",
                     shift_en, dig_rstb_out, anlg_rstb_out, cfg_busy);
        end
        rst = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (dig_rstb_out !== 1'b1 || anlg_rstb_out !== 1'b1 || shift_en !== '0) begin
            tests_failed++;
            $display("FAIL mid_reset_release: got d=%b a=%b shift=%h expected 1 1 0",
                     dig_rstb_out, anlg_rstb_out, shift_en);
        end
        m_shift = '0;
        m_err   = 1'b0;
    endtask

    task automatic test_repair();
        int lat, a_r, d_r, viol, drops;
        do_req(1'b1, 5, -10, 0, lat, a_r, d_r, viol, drops);
        m_shift = exp_therm(5);
        tests_run++;
        if (shift_en !== 24'hFFFFE0 || shift_en !== m_shift) begin
            tests_failed++;
            $display("FAIL repair_shift: got %h expected %h", shift_en, 24'hFFFFE0);
        end
        tests_run++;
        if (lat !== LAT_OK) begin
            tests_failed++;
            $display("FAIL repair_latency: got %0d expected %0d", lat, LAT_OK);
        end
        tests_run++;
        if (a_r < 0 || d_r - a_r !== SETTLE_CYC) begin
            tests_failed++;
            $display("FAIL repair_rel_order: got anlg@%0d dig@%0d expected gap %0d", a_r, d_r, SETTLE_CYC);
        end
        tests_run++;
        if (viol !== 0 || cfg_busy !== 1'b0 || dig_rstb_out !== 1'b1 || anlg_rstb_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL repair_end: got viol=%0d busy=%b d=%b a=%b expected 0 0 1 1",
                     viol, cfg_busy, dig_rstb_out, anlg_rstb_out);
        end
    endtask

    task automatic test_unrepair();
        int lat, a_r, d_r, viol, drops;
        do_req(1'b0, 17, -10, 0, lat, a_r, d_r, viol, drops);
        m_shift = '0;
        tests_run++;
        if (shift_en !== m_shift || viol !== 0 || lat !== LAT_OK) begin
            tests_failed++;
            $display("FAIL unrepair: got shift=%h viol=%0d lat=%0d expected %h 0 %0d",
                     shift_en, viol, lat, m_shift, LAT_OK);
        end
    endtask

    task automatic test_range();
        int lat, a_r, d_r, viol, drops;
        do_req(1'b1, 2, -10, 0, lat, a_r, d_r, viol, drops);
        m_shift = exp_therm(2);
        do_req(1'b1, NUM_IO, -10, 0, lat, a_r, d_r, viol, drops);
        tests_run++;
        if (cfg_err !== 1'b1 || lat !== LAT_ERR) begin
            tests_failed++;
            $display("FAIL range_err: got err=%b lat=%0d expected 1 %0d", cfg_err, lat, LAT_ERR);
        end
        tests_run++;
        if (shift_en !== m_shift || drops !== 0) begin
            tests_failed++;
            $display("FAIL range_unchanged: got shift=%h drops=%0d expected %h 0", shift_en, drops, m_shift);
        end
        do_req(1'b1, 11, -10, 0, lat, a_r, d_r, viol, drops);
        m_shift = exp_therm(11);
        tests_run++;
        if (cfg_err !== 1'b0 || shift_en !== m_shift) begin
            tests_failed++;
            $display("FAIL range_clear: got err=%b shift=%h expected 0 %h", cfg_err, shift_en, m_shift);
        end
    endtask

    task automatic test_busy_ignore();
        int lat, a_r, d_r, viol, drops;
        do_req(1'b1, 3, 25, 9, lat, a_r, d_r, viol, drops);
        m_shift = exp_therm(3);
        tests_run++;
        if (shift_en !== m_shift || lat !== LAT_OK || cfg_err !== 1'b0) begin
            tests_failed++;
            $display("FAIL busy_ignore: got shift=%h lat=%0d err=%b expected %h %0d 0",
                     shift_en, lat, cfg_err, m_shift, LAT_OK);
        end
        repeat (5) @(posedge clk);
        #1;
        tests_run++;
        if (cfg_busy !== 1'b0 || shift_en !== m_shift) begin
            tests_failed++;
            $display("FAIL busy_no_queue: got busy=%b shift=%h expected 0 %h", cfg_busy, shift_en, m_shift);
        end
    endtask

    task automatic test_boundary();
        int lat, a_r, d_r, viol, drops;
        do_req(1'b1, NUM_IO - 1, -10, 0, lat, a_r, d_r, viol, drops);
        tests_run++;
        if (shift_en !== 24'h800000) begin
            tests_failed++;
            $display("FAIL spare_only: got %h expected %h", shift_en, 24'h800000);
        end
        do_req(1'b1, 0, -10, 0, lat, a_r, d_r, viol, drops);
        tests_run++;
        if (shift_en !== 24'hFFFFFF) begin
            tests_failed++;
            $display("FAIL shift_all: got %h expected %h", shift_en, 24'hFFFFFF);
        end
        // Same repair again still pulses the resets
        do_req(1'b1, 0, -10, 0, lat, a_r, d_r, viol, drops);
        m_shift = 24'hFFFFFF;
        tests_run++;
        if (drops < 2 * SETTLE_CYC || lat !== LAT_OK || shift_en !== m_shift) begin
            tests_failed++;
            $display("FAIL repeat_repair: got drops=%0d lat=%0d shift=%h expected >=%0d %0d %h",
                     drops, lat, shift_en, 2 * SETTLE_CYC, LAT_OK, m_shift);
        end
    endtask

    task automatic test_priority();
        @(posedge clk); #1;
        dig_rstb_in = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (dig_rstb_out !== 1'b0 || anlg_rstb_out !== 1'b1) begin
            tests_failed++;
            $display("FAIL prio_dig: got d=%b a=%b expected 0 1", dig_rstb_out, anlg_rstb_out);
        end
        dig_rstb_in  = 1'b1;
        anlg_rstb_in = 1'b0;
        @(posedge clk); #1;
        tests_run++;
        if (dig_rstb_out !== 1'b1 || anlg_rstb_out !== 1'b0) begin
            tests_failed++;
            $display("FAIL prio_anlg: got d=%b a=%b expected 1 0", dig_rstb_out, anlg_rstb_out);
        end
        anlg_rstb_in = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        int lat, a_r, d_r, viol, drops, idx, exp_lat;
        logic red_en;
        for (int n = 0; n < 10; n++) begin
            red_en = ($urandom % 4) != 0;
            idx    = $urandom_range(0, NUM_IO + 3);
            do_req(red_en, idx, -10, 0, lat, a_r, d_r, viol, drops);
            if (red_en && idx >= NUM_IO) begin
                m_err   = 1'b1;
                exp_lat = LAT_ERR;
            end else begin
                m_err   = 1'b0;
                m_shift = red_en ? exp_therm(idx) : '0;
                exp_lat = LAT_OK;
            end
            tests_run++;
            if (shift_en !== m_shift || cfg_err !== m_err || lat !== exp_lat || viol !== 0) begin
                tests_failed++;
                $display("FAIL random[%0d] en=%b idx=%0d: got shift=%h err=%b lat=%0d viol=%0d expected %h %b %0d 0",
                         n, red_en, idx, shift_en, cfg_err, lat, viol, m_shift, m_err, exp_lat);
            end
        end
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst          = 1'b1;
        cfg_req      = 1'b0;
        cfg_red_en   = 1'b0;
        cfg_fail_idx = '0;
        dig_rstb_in  = 1'b1;
        anlg_rstb_in = 1'b1;
        m_shift      = '0;
        m_err        = 1'b0;

        test_reset();
        test_repair();
        test_unrepair();
        test_range();
        test_busy_ignore();
        test_boundary();
        test_priority();
        test_random();

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

`default_nettype wire
